viterbi_out: RTL and testbench
==============================

VITERBI_OUT -- requirements
Module: viterbi_out

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning output FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter NORM_TH, default 7'd64, meaning minimum-PM threshold for a normalisation request.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  one trellis step completed by the four ACS_mem stages this cycle.
REQ-006 SHALL have ports PM_0..PM_3  input  7 each  path metrics of states 0..3.
REQ-007 SHALL have ports data_0..data_3  input  8 each  survivor registers of states 0..3; bit 7 is the oldest decision.
REQ-008 SHALL have port flush  input  1  single-cycle pulse marking end of frame.
REQ-009 SHALL have port dec_ready  input  1  downstream accepts a bit this cycle.
REQ-010 SHALL have port dec_bit  output  1  decoded bit at the FIFO head.
REQ-011 SHALL have port dec_valid  output  1  dec_bit is valid; a transfer occurs when dec_valid and dec_ready are both high.
REQ-012 SHALL have port norm_req  output  1  registered; minimum PM of the last step >= NORM_TH.
REQ-013 SHALL have port err  output  1  sticky; a bit or step was lost.

Function
REQ-014 SHALL select, on every in_valid, the state with the smallest PM; ties SHALL resolve to the lowest index.
REQ-015 SHALL implement states WARMUP, RUN and FLUSH, with WARMUP entered on reset.
REQ-016 In WARMUP, a 3-bit step counter SHALL count in_valid pulses; after 7 counted steps, the next in_valid SHALL push a bit and move the FSM to RUN. No bit SHALL be pushed during the first 7 steps.
REQ-017 In RUN, each in_valid SHALL push bit 7 of the winning survivor into the FIFO.
REQ-018 Latency: a bit pushed on the in_valid of cycle t SHALL be visible as dec_bit with dec_valid in cycle t+1 when the FIFO was empty.
REQ-019 A flush in RUN SHALL latch winner data[6:0] (with same-cycle in_valid processed first) and enter FLUSH.
REQ-020 In FLUSH, the FSM SHALL push latched bits 6 down to 0, one per cycle, stalling while the FIFO is full; after bit 0 it SHALL enter WARMUP with the counter cleared.
REQ-021 A flush in WARMUP SHALL clear the counter and push nothing.
REQ-022 An in_valid during FLUSH SHALL be dropped and SHALL set err.
REQ-023 A push into a full FIFO with no same-cycle pop SHALL drop the bit and set err; a push and pop in the same cycle when full SHALL both succeed.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; bit order SHALL be preserved.
REQ-025 norm_req SHALL update only on in_valid; PM comparison is unsigned 7-bit.
REQ-026 err SHALL clear only on reset.

Reset
REQ-027 When rst is low at a clock edge: dec_bit=0, dec_valid=0, norm_req=0, err=0, FIFO empty, counter=0, FSM=WARMUP.
REQ-028 A reset asserted mid-FLUSH SHALL discard the latched bits and all FIFO contents.

Structure
REQ-029 Package viterbi_pkg SHALL hold PM_W=7, SURV_W=8, NSTATE=4 and the FSM state enum.
REQ-030 The minimum search SHALL be a combinational sub-module, pm_min4, returning the 2-bit index and the 7-bit minimum PM.

Verification
REQ-031 Reset, then 8 in_valid steps with PM=(5,3,9,3) and data_1=8'h80 -> no output for steps 1-7; step 8 pushes 1 (state 1 wins the tie); dec_valid=1 in the following cycle.
REQ-032 In RUN with dec_ready=0, push 5 bits (FIFO_DEPTH=4) -> first 4 bits retained, err=1; raising dec_ready drains them in order.
REQ-033 flush in RUN with winner data=8'h55 -> bits 1,0,1,0,1,0,1 emitted after the in-step bit, then FSM=WARMUP.
REQ-034 in_valid during FLUSH -> step dropped, err=1, flush sequence unaffected.
REQ-035 PM_2=7'd63 minimum, then 7'd64 minimum -> norm_req 0 then 1, each one cycle after its in_valid.
REQ-036 rst low at the 3rd flush-push cycle -> all outputs 0 on the next cycle, remaining flush bits never appear.

Source files
------------

// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - shared widths, counts and FSM encoding for the Viterbi output stage
package viterbi_pkg;

    localparam int PM_W   = 7;
    localparam int SURV_W = 8;
    localparam int NSTATE = 4;

    localparam logic [2:0] WARMUP_STEPS = 3'd7;
    localparam logic [2:0] FLUSH_FIRST  = 3'd6;

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_RUN    = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

endpackage

// File: rtl/pm_min4.sv
// rtl/pm_min4.sv - combinational minimum search over four path metrics
module pm_min4
    import viterbi_pkg::*;
(
    input  logic [PM_W-1:0]            i_pm0,
    input  logic [PM_W-1:0]            i_pm1,
    input  logic [PM_W-1:0]            i_pm2,
    input  logic [PM_W-1:0]            i_pm3,
    output logic [$clog2(NSTATE)-1:0]  o_idx,
    output logic [PM_W-1:0]            o_min
);

    logic            w_sel01;
    logic            w_sel23;
    logic            w_hi;
    logic [PM_W-1:0] w_min01;
    logic [PM_W-1:0] w_min23;

    // Strict less-than at every level keeps the lower index on ties.
    assign w_sel01 = i_pm1 < i_pm0;
    assign w_min01 = w_sel01 ? i_pm1 : i_pm0;
    assign w_sel23 = i_pm3 < i_pm2;
    assign w_min23 = w_sel23 ? i_pm3 : i_pm2;
    assign w_hi    = w_min23 < w_min01;

    assign o_idx = w_hi ? {1'b1, w_sel23} : {1'b0, w_sel01};
    assign o_min = w_hi ? w_min23 : w_min01;

endmodule

// File: rtl/viterbi_out.sv
// rtl/viterbi_out.sv - traceback output stage: winner select, warmup/flush FSM, decoded-bit FIFO
module viterbi_out
    import viterbi_pkg::*;
#(
    parameter int              FIFO_DEPTH = 4,
    parameter logic [PM_W-1:0] NORM_TH    = 7'd64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [PM_W-1:0]   PM_0,
    input  logic [PM_W-1:0]   PM_1,
    input  logic [PM_W-1:0]   PM_2,
    input  logic [PM_W-1:0]   PM_3,
    input  logic [SURV_W-1:0] data_0,
    input  logic [SURV_W-1:0] data_1,
    input  logic [SURV_W-1:0] data_2,
    input  logic [SURV_W-1:0] data_3,
    input  logic              flush,
    input  logic              dec_ready,
    output logic              dec_bit,
    output logic              dec_valid,
    output logic              norm_req,
    output logic              err
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [$clog2(NSTATE)-1:0] w_win_idx;
    logic [PM_W-1:0]           w_min_pm;
    logic [SURV_W-1:0]         w_win_data;

    state_t          r_state, w_state_nxt;
    logic [2:0]      r_cnt, w_cnt_nxt;
    logic [2:0]      r_fidx, w_fidx_nxt;
    logic [6:0]      r_lat, w_lat_nxt;
    logic            w_push;
    logic            w_push_bit;
    logic            w_step_lost;

    logic [FIFO_DEPTH-1:0] r_mem;
    logic [AW-1:0]         r_wr;
    logic [AW-1:0]         r_rd;
    logic [AW:0]           r_count;
    logic                  r_norm;
    logic                  r_err;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_can_push;
    logic                  w_do_push;

    pm_min4 u_pm_min4 (
        .i_pm0 (PM_0),
        .i_pm1 (PM_1),
        .i_pm2 (PM_2),
        .i_pm3 (PM_3),
        .o_idx (w_win_idx),
        .o_min (w_min_pm)
    );

    always_comb begin
        w_win_data = data_0;
        case (w_win_idx)
            2'd1:    w_win_data = data_1;
            2'd2:    w_win_data = data_2;
            2'd3:    w_win_data = data_3;
            default: w_win_data = data_0;
        endcase
    end

    assign dec_valid  = (r_count != '0);
    assign dec_bit    = dec_valid & r_mem[r_rd];
    assign norm_req   = r_norm;
    assign err        = r_err;
    assign w_full     = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_pop      = dec_valid & dec_ready;
    assign w_can_push = ~w_full | w_pop;
    assign w_do_push  = w_push & w_can_push;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_WARMUP;
            r_cnt   <= '0;
            r_fidx  <= '0;
            r_lat   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_fidx  <= w_fidx_nxt;
            r_lat   <= w_lat_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_fidx_nxt  = r_fidx;
        w_lat_nxt   = r_lat;
        w_push      = 1'b0;
        w_push_bit  = 1'b0;
        w_step_lost = 1'b0;
        case (r_state)
            ST_WARMUP: begin
                if (flush) begin
                    w_cnt_nxt = '0;
                end else if (in_valid) begin
                    if (r_cnt == WARMUP_STEPS) begin
                        w_push      = 1'b1;
                        w_push_bit  = w_win_data[SURV_W-1];
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_cnt_nxt = r_cnt + 3'd1;
                    end
                end
            end
            ST_RUN: begin
                if (in_valid) begin
                    w_push     = 1'b1;
                    w_push_bit = w_win_data[SURV_W-1];
                end
                if (flush) begin
                    w_lat_nxt   = w_win_data[6:0];
                    w_fidx_nxt  = FLUSH_FIRST;
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                w_step_lost = in_valid;
                // Only offer a flush bit when the FIFO can take it, so flushing never drops.
                if (w_can_push) begin
                    w_push     = 1'b1;
                    w_push_bit = r_lat[r_fidx];
                    if (r_fidx == '0) begin
                        w_state_nxt = ST_WARMUP;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_fidx_nxt = r_fidx - 3'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_WARMUP;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mem   <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_norm  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr] <= w_push_bit;
                r_wr        <= r_wr + AW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            case ({w_do_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (in_valid) begin
                r_norm <= (w_min_pm >= NORM_TH);
            end
            if ((w_push && !w_can_push) || w_step_lost) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_viterbi_out.sv
// tb/tb_viterbi_out.sv - directed and random bench for viterbi_out against a queue-based model
module tb_viterbi_out;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic       iv;
    logic [6:0] pm [4];
    logic [7:0] dat [4];
    logic       fl;
    logic       rdy;
    logic       dec_bit;
    logic       dec_valid;
    logic       norm_req;
    logic       err;

    int n_tests = 0;
    int n_fail  = 0;

    bit m_q[$];
    bit m_pend[$];
    int m_steps;
    int m_mode;
    bit m_err;
    bit m_norm;

    viterbi_out #(.FIFO_DEPTH(DEPTH), .NORM_TH(7'd64)) dut (
        .clk       (clk),
        .rst       (rst_n),
        .in_valid  (iv),
        .PM_0      (pm[0]),
        .PM_1      (pm[1]),
        .PM_2      (pm[2]),
        .PM_3      (pm[3]),
        .data_0    (dat[0]),
        .data_1    (dat[1]),
        .data_2    (dat[2]),
        .data_3    (dat[3]),
        .flush     (fl),
        .dec_ready (rdy),
        .dec_bit   (dec_bit),
        .dec_valid (dec_valid),
        .norm_req  (norm_req),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: mode 0 warming up, 1 running, 2 emitting the latched tail bits.
    function automatic void model_step();
        int w;
        bit pop, full, push, pbit;
        if (!rst_n) begin
            m_q.delete();
            m_pend.delete();
            m_steps = 0;
            m_mode  = 0;
            m_err   = 0;
            m_norm  = 0;
            return;
        end
        w = 0;
        for (int s = 1; s < 4; s++) if (pm[s] < pm[w]) w = s;
        pop  = (m_q.size() > 0) && rdy;
        full = (m_q.size() == DEPTH);
        push = 0;
        pbit = 0;
        if (iv) m_norm = (pm[w] >= 64);
        case (m_mode)
            0: begin
                if (fl) m_steps = 0;
                else if (iv) begin
                    if (m_steps == 7) begin
                        push = 1; pbit = dat[w][7]; m_mode = 1;
                    end else m_steps++;
                end
            end
            1: begin
                if (iv) begin push = 1; pbit = dat[w][7]; end
                if (fl) begin
                    for (int b = 6; b >= 0; b--) m_pend.push_back(dat[w][b]);
                    m_mode = 2;
                end
            end
            default: begin
                if (iv) m_err = 1;
                if (!full || pop) begin
                    push = 1;
                    pbit = m_pend.pop_front();
                    if (m_pend.size() == 0) begin m_mode = 0; m_steps = 0; end
                end
            end
        endcase
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (full && !pop) m_err = 1;
            else m_q.push_back(pbit);
        end
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".dec_valid"}, dec_valid, m_q.size() > 0);
        if (m_q.size() > 0) check({tag, ".dec_bit"}, dec_bit, m_q[0]);
        check({tag, ".err"}, err, m_err);
        check({tag, ".norm_req"}, norm_req, m_norm);
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic rand_data();
        for (int s = 0; s < 4; s++) begin
            pm[s]  = 7'($urandom_range(0, 127));
            dat[s] = 8'($urandom);
        end
    endtask

    task automatic warm(input string tag);
        for (int k = 0; k < 8; k++) begin
            rand_data();
            iv = 1'b1;
            tick(tag);
        end
        iv = 1'b0;
    endtask

    task automatic idle(input string tag, input int n);
        iv = 1'b0;
        fl = 1'b0;
        for (int k = 0; k < n; k++) tick(tag);
    endtask

    logic [7:0] got;

    initial begin
        rst_n = 1'b0; iv = 1'b0; fl = 1'b0; rdy = 1'b0;
        for (int s = 0; s < 4; s++) begin pm[s] = '0; dat[s] = '0; end

        // Reset state
        tick("reset");
        tick("reset");
        check("reset.dec_bit0", dec_bit, 1'b0);
        check("reset.valid0", dec_valid, 1'b0);
        rst_n = 1'b1;

        // Warmup: 7 silent steps, 8th pushes the tie-winner's (state 1) oldest bit
        pm[0] = 7'd5; pm[1] = 7'd3; pm[2] = 7'd9; pm[3] = 7'd3;
        dat[0] = 8'h00; dat[1] = 8'h80; dat[2] = 8'hFF; dat[3] = 8'h00;
        iv = 1'b1;
        for (int k = 0; k < 7; k++) tick("warmup");
        check("warmup.no_out", dec_valid, 1'b0);
        tick("warmup.step8");
        check("step8.valid", dec_valid, 1'b1);
        check("step8.bit", dec_bit, 1'b1);
        iv = 1'b0; rdy = 1'b1;
        tick("drain1");

        // Normalisation threshold boundary
        pm[0] = 7'd70; pm[1] = 7'd70; pm[2] = 7'd63; pm[3] = 7'd70;
        iv = 1'b1;
        tick("norm63");
        check("norm63.direct", norm_req, 1'b0);
        pm[0] = 7'd100; pm[1] = 7'd100; pm[2] = 7'd64; pm[3] = 7'd127;
        tick("norm64");
        check("norm64.direct", norm_req, 1'b1);
        iv = 1'b0;
        pm[0] = 7'd0;
        tick("norm_hold");
        check("norm_hold.direct", norm_req, 1'b1);
        idle("drain2", 2);

        // Flush in RUN with winner data 0x55
        pm[0] = 7'd1; pm[1] = 7'd20; pm[2] = 7'd20; pm[3] = 7'd20;
        dat[0] = 8'h55; dat[1] = 8'hAA; dat[2] = 8'hAA; dat[3] = 8'hAA;
        iv = 1'b1; fl = 1'b1;
        got = '0;
        tick("flush55");
        got = {got[6:0], dec_bit};
        iv = 1'b0; fl = 1'b0;
        for (int k = 0; k < 7; k++) begin
            tick("flush55.seq");
            check("flush55.valid", dec_valid, 1'b1);
            got = {got[6:0], dec_bit};
        end
        check("flush55.b7", got[7], 1'b0);
        n_tests++;
        assert (got === 8'h55) else begin
            n_fail++;
            $error("FAIL flush55.order: observed %h expected 55", got);
        end
        idle("flush55.tail", 2);
        iv = 1'b1;
        for (int k = 0; k < 7; k++) begin rand_data(); tick("rewarm"); end
        check("rewarm.no_out", dec_valid, 1'b0);
        tick("rewarm.step8");
        check("rewarm.valid", dec_valid, 1'b1);
        iv = 1'b0;
        idle("rewarm.drain", 2);

        // in_valid during FLUSH is dropped and flags err
        check("pre034.err", err, 1'b0);
        rand_data();
        fl = 1'b1;
        tick("flush034");
        fl = 1'b0;
        tick("flush034.p1");
        iv = 1'b1; rand_data();
        tick("flush034.iv");
        check("flush034.err", err, 1'b1);
        idle("flush034.rest", 10);

        // Overflow with dec_ready low
        rst_n = 1'b0; tick("rst2"); rst_n = 1'b1;
        rdy = 1'b1;
        warm("warm2");
        idle("warm2.drain", 2);
        rdy = 1'b0;
        iv = 1'b1;
        for (int k = 0; k < 4; k++) begin rand_data(); tick("fill"); end
        check("fill.noerr", err, 1'b0);
        rand_data();
        tick("overflow");
        check("overflow.err", err, 1'b1);
        iv = 1'b0; rdy = 1'b1;
        idle("ovf.drain", 5);
        check("ovf.empty", dec_valid, 1'b0);

        // Reset mid-flush discards everything
        rst_n = 1'b0; tick("rst3"); rst_n = 1'b1;
        rdy = 1'b1;
        warm("warm3");
        idle("warm3.drain", 2);
        for (int s = 0; s < 4; s++) pm[s] = 7'd10;
        dat[0] = 8'hFF;
        fl = 1'b1;
        tick("flush036");
        fl = 1'b0;
        tick("flush036.p1");
        tick("flush036.p2");
        rst_n = 1'b0;
        tick("flush036.rst");
        check("rst036.valid", dec_valid, 1'b0);
        check("rst036.bit", dec_bit, 1'b0);
        check("rst036.norm", norm_req, 1'b0);
        check("rst036.err", err, 1'b0);
        rst_n = 1'b1;
        idle("rst036.after", 10);
        check("rst036.gone", dec_valid, 1'b0);

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            rand_data();
            iv    = ($urandom_range(0, 3) != 0);
            rdy   = ($urandom_range(0, 3) != 0);
            fl    = ($urandom_range(0, 39) == 0);
            rst_n = ($urandom_range(0, 299) != 0);
            tick("random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
